// File: rtl/sd_pkg.sv
// Shared definitions for the SD multi-sector transfer scheduler.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_W    = 2'b01,
    OWN_R    = 2'b10
  } owner_t;

  localparam int BUSY_TMO_DEF = 1024;

endpackage

// File: rtl/sd_rr_arb.sv
// Two-requester round-robin arbiter; win is one-hot {R, W}.
module sd_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req_w,
  input  logic       req_r,
  output logic       grant,
  output logic [1:0] win
);

  logic last_r;

  // Pick a winner; on a tie the client that was not served last wins
  always_comb begin
    win = 2'b00;
    if (en) begin
      if (req_w && req_r) begin
        win = last_r ? 2'b01 : 2'b10;
      end else if (req_w) begin
        win = 2'b01;
      end else if (req_r) begin
        win = 2'b10;
      end
    end
    grant = |win;
  end

  // Remember who was served last; starting as R lets W win the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (grant) begin
      last_r <= win[1];
    end
  end

endmodule

// File: rtl/sd_xfer_sched.sv
// Multi-sector burst sequencer sharing one SD controller between a
// capture writer (W) and a playback reader (R).
module sd_xfer_sched
  import sd_pkg::*;
#(
  parameter int BUSY_TMO = BUSY_TMO_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             sd_init_done,
  output logic             wr_start_en,
  output logic [31:0]      wr_sec_addr,
  input  logic             wr_busy,
  output logic             rd_start_en,
  output logic [31:0]      rd_sec_addr,
  input  logic             rd_busy,
  input  logic             cw_req,
  input  logic [31:0]      cw_start_sec,
  input  logic [CNT_W-1:0] cw_sec_cnt,
  output logic             cw_ack,
  output logic             cw_done,
  input  logic             cr_req,
  input  logic [31:0]      cr_start_sec,
  input  logic [CNT_W-1:0] cr_sec_cnt,
  output logic             cr_ack,
  output logic             cr_done,
  output logic             xfer_err,
  output logic [1:0]       owner
);

  localparam int TMO_W = $clog2(BUSY_TMO) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 2);

  state_t           state;
  owner_t           owner_q;
  logic [31:0]      addr;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             arb_en;
  logic             grant;
  logic [1:0]       win;
  logic             busy_sel;

  assign arb_en   = (state == ST_IDLE) && sd_init_done && !rst;
  assign busy_sel = (owner_q == OWN_W) ? wr_busy : rd_busy;
  assign cw_ack   = grant & win[0];
  assign cr_ack   = grant & win[1];
  assign owner    = owner_q;

  sd_rr_arb u_arb (
    .clk   (clk_ref),
    .rst   (rst),
    .en    (arb_en),
    .req_w (cw_req),
    .req_r (cr_req),
    .grant (grant),
    .win   (win)
  );

  // Burst FSM: each output pulse becomes visible in the state that owns it
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner_q     <= OWN_NONE;
      addr        <= '0;
      cnt         <= '0;
      tmo_cnt     <= '0;
      wr_start_en <= 1'b0;
      rd_start_en <= 1'b0;
      wr_sec_addr <= '0;
      rd_sec_addr <= '0;
      cw_done     <= 1'b0;
      cr_done     <= 1'b0;
      xfer_err    <= 1'b0;
    end else begin
      wr_start_en <= 1'b0;
      rd_start_en <= 1'b0;
      cw_done     <= 1'b0;
      cr_done     <= 1'b0;
      xfer_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state <= ST_LOAD;
            if (win[0]) begin
              owner_q <= OWN_W;
              addr    <= cw_start_sec;
              cnt     <= cw_sec_cnt;
              cw_done <= (cw_sec_cnt == '0);
            end else begin
              owner_q <= OWN_R;
              addr    <= cr_start_sec;
              cnt     <= cr_sec_cnt;
              cr_done <= (cr_sec_cnt == '0);
            end
          end
        end
        ST_LOAD: begin
          if (cnt == '0) begin
            owner_q <= OWN_NONE;
            state   <= ST_IDLE;
          end else begin
            if (owner_q == OWN_W) begin
              wr_sec_addr <= addr;
              wr_start_en <= 1'b1;
            end else begin
              rd_sec_addr <= addr;
              rd_start_en <= 1'b1;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (busy_sel) begin
            state <= ST_WAIT_LO;
          end else if (tmo_cnt == TMO_LAST) begin
            cw_done  <= (owner_q == OWN_W);
            cr_done  <= (owner_q == OWN_R);
            xfer_err <= 1'b1;
            owner_q  <= OWN_NONE;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!busy_sel) begin
            addr <= addr + 32'd1;
            cnt  <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              cw_done <= (owner_q == OWN_W);
              cr_done <= (owner_q == OWN_R);
              owner_q <= OWN_NONE;
              state   <= ST_IDLE;
            end else begin
              if (owner_q == OWN_W) begin
                wr_sec_addr <= addr + 32'd1;
                wr_start_en <= 1'b1;
              end else begin
                rd_sec_addr <= addr + 32'd1;
                rd_start_en <= 1'b1;
              end
              state <= ST_ISSUE;
            end
          end
        end
        default: begin
          owner_q <= OWN_NONE;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_xfer_sched.sv
// Directed bench for sd_xfer_sched with a simple SD controller busy model.
module tb_sd_xfer_sched;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        sd_init_done;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        wr_busy;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        cw_req;
  logic [31:0] cw_start_sec;
  logic [15:0] cw_sec_cnt;
  logic        cw_ack;
  logic        cw_done;
  logic        cr_req;
  logic [31:0] cr_start_sec;
  logic [15:0] cr_sec_cnt;
  logic        cr_ack;
  logic        cr_done;
  logic        xfer_err;
  logic [1:0]  owner;

  int checks   = 0;
  int failures = 0;

  // Controller model knobs
  int wr_len   = 50;
  int rd_len   = 50;
  bit rd_never = 1'b0;
  int wr_left  = 0;
  int rd_left  = 0;

  // Monitor state
  bit          mon_clear = 1'b0;
  int          cyc = 0;
  logic [31:0] wr_addrs[$];
  logic [31:0] rd_addrs[$];
  int          wr_cycs[$];
  int          rd_cycs[$];
  int          ack_order[$];
  int          w_ack_cnt = 0;
  int          r_ack_cnt = 0;
  int          w_ack_cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          last_done_cyc = 0;
  bit          last_done_err = 1'b0;
  int          w_ack_base = 0;
  int          r_ack_base = 0;

  sd_xfer_sched #(.BUSY_TMO(16), .CNT_W(16)) dut (
    .clk_ref      (clk_ref),
    .rst          (rst),
    .sd_init_done (sd_init_done),
    .wr_start_en  (wr_start_en),
    .wr_sec_addr  (wr_sec_addr),
    .wr_busy      (wr_busy),
    .rd_start_en  (rd_start_en),
    .rd_sec_addr  (rd_sec_addr),
    .rd_busy      (rd_busy),
    .cw_req       (cw_req),
    .cw_start_sec (cw_start_sec),
    .cw_sec_cnt   (cw_sec_cnt),
    .cw_ack       (cw_ack),
    .cw_done      (cw_done),
    .cr_req       (cr_req),
    .cr_start_sec (cr_start_sec),
    .cr_sec_cnt   (cr_sec_cnt),
    .cr_ack       (cr_ack),
    .cr_done      (cr_done),
    .xfer_err     (xfer_err),
    .owner        (owner)
  );

  always #5 clk_ref = ~clk_ref;

  // Write path busy: rises the cycle after a start pulse, stays high wr_len cycles
  always @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      wr_busy <= 1'b0;
      wr_left <= 0;
    end else if (wr_start_en) begin
      wr_busy <= 1'b1;
      wr_left <= wr_len;
    end else if (wr_left > 1) begin
      wr_left <= wr_left - 1;
    end else begin
      wr_busy <= 1'b0;
      wr_left <= 0;
    end
  end

  // Read path busy, optionally never raised to provoke a timeout
  always @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      rd_busy <= 1'b0;
      rd_left <= 0;
    end else if (rd_start_en && !rd_never) begin
      rd_busy <= 1'b1;
      rd_left <= rd_len;
    end else if (rd_left > 1) begin
      rd_left <= rd_left - 1;
    end else begin
      rd_busy <= 1'b0;
      rd_left <= 0;
    end
  end

  // Record pulses, addresses and cycle stamps seen at each active edge
  always @(posedge clk_ref) begin
    if (mon_clear) begin
      wr_addrs.delete();
      rd_addrs.delete();
      wr_cycs.delete();
      rd_cycs.delete();
      ack_order.delete();
      w_ack_cnt = 0;
      r_ack_cnt = 0;
      done_cnt  = 0;
      err_cnt   = 0;
    end else begin
      if (wr_start_en) begin
        wr_addrs.push_back(wr_sec_addr);
        wr_cycs.push_back(cyc);
      end
      if (rd_start_en) begin
        rd_addrs.push_back(rd_sec_addr);
        rd_cycs.push_back(cyc);
      end
      if (cw_ack) begin
        w_ack_cnt++;
        w_ack_cyc = cyc;
        ack_order.push_back(1);
      end
      if (cr_ack) begin
        r_ack_cnt++;
        ack_order.push_back(2);
      end
      if (cw_done || cr_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        last_done_err = xfer_err;
        if (xfer_err) err_cnt++;
      end
    end
    cyc++;
  end

  task automatic clear_mon();
    @(negedge clk_ref);
    mon_clear = 1'b1;
    @(negedge clk_ref);
    mon_clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_ref);
    rst = 1'b1;
    repeat (2) @(negedge clk_ref);
    rst = 1'b0;
  endtask

  task automatic req_w(input logic [31:0] start, input logic [15:0] cnt);
    cw_start_sec = start;
    cw_sec_cnt   = cnt;
    w_ack_base   = w_ack_cnt;
    cw_req       = 1'b1;
  endtask

  task automatic req_r(input logic [31:0] start, input logic [15:0] cnt);
    cr_start_sec = start;
    cr_sec_cnt   = cnt;
    r_ack_base   = r_ack_cnt;
    cr_req       = 1'b1;
  endtask

  // Drop each request once acked and wait until no burst is left in flight
  task automatic run_until_quiet(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_ref);
      if (cw_req && w_ack_cnt > w_ack_base) cw_req = 1'b0;
      if (cr_req && r_ack_cnt > r_ack_base) cr_req = 1'b0;
      if (!cw_req && !cr_req && owner == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk_ref);
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk_ref);
    #1;
    checks++;
    if ({wr_start_en, rd_start_en, cw_ack, cr_ack, cw_done, cr_done, xfer_err, owner} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0",
               {wr_start_en, rd_start_en, cw_ack, cr_ack, cw_done, cr_done, xfer_err, owner});
    end
    checks++;
    if ({wr_sec_addr, rd_sec_addr} !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_addr: got %h/%h expected 0/0", wr_sec_addr, rd_sec_addr);
    end
    rst = 1'b0;
    clear_mon();
    req_w(32'h80, 16'd1);
    repeat (10) @(negedge clk_ref);
    #1;
    checks++;
    if (w_ack_cnt !== 0 || cw_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL init_gate: got acks=%0d expected 0", w_ack_cnt);
    end
    sd_init_done = 1'b1;
    #1;
    checks++;
    if (cw_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL init_release_ack: got %b expected 1", cw_ack);
    end
    run_until_quiet(1000, ok);
    checks++;
    if (!ok || done_cnt !== 1 || wr_addrs.size() !== 1) begin
      failures++;
      $display("[TB] FAIL init_burst: got ok=%0d dones=%0d starts=%0d expected 1/1/1",
               ok, done_cnt, wr_addrs.size());
    end else begin
      checks++;
      if (wr_addrs[0] !== 32'h80) begin
        failures++;
        $display("[TB] FAIL init_addr: got %h expected 00000080", wr_addrs[0]);
      end
    end
  endtask

  task automatic test_write_burst();
    bit ok;
    logic [31:0] exp_addr[3];
    exp_addr[0] = 32'h100;
    exp_addr[1] = 32'h101;
    exp_addr[2] = 32'h102;
    clear_mon();
    req_w(32'h100, 16'd3);
    run_until_quiet(2000, ok);
    checks++;
    if (!ok || wr_addrs.size() !== 3) begin
      failures++;
      $display("[TB] FAIL wb_starts: got ok=%0d starts=%0d expected 1/3", ok, wr_addrs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addrs[i] !== exp_addr[i]) begin
          failures++;
          $display("[TB] FAIL wb_addr%0d: got %h expected %h", i, wr_addrs[i], exp_addr[i]);
        end
      end
      checks++;
      if (wr_cycs[0] - w_ack_cyc !== 2) begin
        failures++;
        $display("[TB] FAIL wb_ack_to_start: got %0d expected 2", wr_cycs[0] - w_ack_cyc);
      end
    end
    checks++;
    if (w_ack_cnt !== 1 || done_cnt !== 1 || err_cnt !== 0 || rd_addrs.size() !== 0) begin
      failures++;
      $display("[TB] FAIL wb_pulses: got acks=%0d dones=%0d errs=%0d rd_starts=%0d expected 1/1/0/0",
               w_ack_cnt, done_cnt, err_cnt, rd_addrs.size());
    end
  endtask

  task automatic test_arbitration();
    bit ok;
    do_reset();
    clear_mon();
    for (int round = 0; round < 2; round++) begin
      req_w(32'h10, 16'd1);
      req_r(32'h20, 16'd1);
      run_until_quiet(2000, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL arb_round%0d_timeout: got not idle expected idle", round);
      end
    end
    checks++;
    if (ack_order.size() !== 4) begin
      failures++;
      $display("[TB] FAIL arb_ack_count: got %0d expected 4", ack_order.size());
    end else begin
      checks++;
      if (ack_order[0] !== 1 || ack_order[1] !== 2 || ack_order[2] !== 1 || ack_order[3] !== 2) begin
        failures++;
        $display("[TB] FAIL arb_order: got %0d%0d%0d%0d expected 1212",
                 ack_order[0], ack_order[1], ack_order[2], ack_order[3]);
      end
    end
    checks++;
    if (rd_addrs.size() !== 2 || wr_addrs.size() !== 2 || done_cnt !== 4) begin
      failures++;
      $display("[TB] FAIL arb_bursts: got wr=%0d rd=%0d dones=%0d expected 2/2/4",
               wr_addrs.size(), rd_addrs.size(), done_cnt);
    end else begin
      checks++;
      if (rd_addrs[0] !== 32'h20 || wr_addrs[0] !== 32'h10) begin
        failures++;
        $display("[TB] FAIL arb_addr: got wr=%h rd=%h expected 00000010/00000020",
                 wr_addrs[0], rd_addrs[0]);
      end
    end
  endtask

  task automatic test_zero_count();
    bit ok;
    clear_mon();
    req_w(32'h55, 16'd0);
    run_until_quiet(200, ok);
    checks++;
    if (!ok || w_ack_cnt !== 1 || done_cnt !== 1 || wr_addrs.size() !== 0) begin
      failures++;
      $display("[TB] FAIL zero_pulses: got ok=%0d acks=%0d dones=%0d starts=%0d expected 1/1/1/0",
               ok, w_ack_cnt, done_cnt, wr_addrs.size());
    end
    checks++;
    if (last_done_cyc - w_ack_cyc !== 1 || last_done_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_done: got delay=%0d err=%0d expected 1/0",
               last_done_cyc - w_ack_cyc, last_done_err);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mon();
    rd_never = 1'b1;
    req_r(32'h40, 16'd2);
    run_until_quiet(500, ok);
    rd_never = 1'b0;
    checks++;
    if (!ok || rd_addrs.size() !== 1 || done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL tmo_pulses: got ok=%0d starts=%0d dones=%0d expected 1/1/1",
               ok, rd_addrs.size(), done_cnt);
    end else begin
      checks++;
      if (last_done_cyc - rd_cycs[0] !== 16 || last_done_err !== 1'b1) begin
        failures++;
        $display("[TB] FAIL tmo_done: got delay=%0d err=%0d expected 16/1",
                 last_done_cyc - rd_cycs[0], last_done_err);
      end
    end
    checks++;
    if (owner !== 2'b00) begin
      failures++;
      $display("[TB] FAIL tmo_owner: got %b expected 00", owner);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_addr[3];
    exp_addr[0] = 32'hFFFF_FFFE;
    exp_addr[1] = 32'hFFFF_FFFF;
    exp_addr[2] = 32'h0000_0000;
    clear_mon();
    req_w(32'hFFFF_FFFE, 16'd3);
    run_until_quiet(2000, ok);
    checks++;
    if (!ok || wr_addrs.size() !== 3) begin
      failures++;
      $display("[TB] FAIL wrap_starts: got ok=%0d starts=%0d expected 1/3", ok, wr_addrs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addrs[i] !== exp_addr[i]) begin
          failures++;
          $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, wr_addrs[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_mon();
    req_w(32'h200, 16'd3);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_ref);
      if (cw_req && w_ack_cnt > w_ack_base) cw_req = 1'b0;
      if (wr_addrs.size() >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL rstmid_second_start: got none expected start");
    end
    repeat (10) @(negedge clk_ref);
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_start_en, rd_start_en, cw_ack, cr_ack, cw_done, cr_done, xfer_err, owner} !== 9'd0 ||
        {wr_sec_addr, rd_sec_addr} !== 64'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs: got ctrl=%b wr=%h rd=%h expected 0",
               {wr_start_en, rd_start_en, cw_ack, cr_ack, cw_done, cr_done, xfer_err, owner},
               wr_sec_addr, rd_sec_addr);
    end
    repeat (2) @(negedge clk_ref);
    rst = 1'b0;
    repeat (5) @(negedge clk_ref);
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL rstmid_no_done: got %0d expected 0", done_cnt);
    end
    req_w(32'h300, 16'd1);
    run_until_quiet(1000, ok);
    checks++;
    if (!ok || done_cnt !== 1 || wr_addrs.size() !== 3) begin
      failures++;
      $display("[TB] FAIL rstmid_after: got ok=%0d dones=%0d starts=%0d expected 1/1/3",
               ok, done_cnt, wr_addrs.size());
    end else begin
      checks++;
      if (wr_addrs[2] !== 32'h300 || last_done_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rstmid_after_addr: got %h err=%0d expected 00000300/0",
                 wr_addrs[2], last_done_err);
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    rst          = 1'b1;
    sd_init_done = 1'b0;
    cw_req       = 1'b0;
    cr_req       = 1'b0;
    cw_start_sec = '0;
    cw_sec_cnt   = '0;
    cr_start_sec = '0;
    cr_sec_cnt   = '0;
    $display("[TB] starting sd_xfer_sched bench");
    test_reset();
    test_write_burst();
    test_arbitration();
    test_zero_count();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
